// File: rtl/mac_out_collector_pkg.sv
// mac_out_collector_pkg: shared defaults, pointer width and psum type for the output collector
package mac_out_collector_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL = 8;
  localparam int OUT_DEPTH = 16;
  localparam int PTR_W = $clog2(OUT_DEPTH) + 1;
  typedef logic signed [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/mac_out_collector_if.sv
// mac_out_collector_if: array-side write bus and SRAM-side aligned-row read bus
// in/wr: column psums and strobes; rd: pop a row; out/o_valid/o_full/o_overflow: aligned row and flags
interface mac_out_collector_if import mac_out_collector_pkg::*; #(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW
);
  logic [psum_bw*col-1:0] in;
  logic [psum_bw*col-1:0] out;
  logic [col-1:0] wr;
  logic rd;
  logic o_valid;
  logic o_full;
  logic o_overflow;
  modport master(output in, wr, rd, input out, o_valid, o_full, o_overflow);
  modport slave(input in, wr, rd, output out, o_valid, o_full, o_overflow);
endinterface

// File: rtl/mac_out_col_fifo.sv
// mac_out_col_fifo: single-column first-word-fall-through FIFO with wrap-bit pointers
// clk, reset (async active-low); din/wr: write side; pop: advance head; dout: head entry;
// empty/full: occupancy; drop: a write was refused this cycle because the column is full
module mac_out_col_fifo import mac_out_collector_pkg::*; #(
  parameter int psum_bw = PSUM_BW,
  parameter int depth = OUT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] din,
  input  logic               wr,
  input  logic               pop,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);
  localparam int aw = $clog2(depth);
  logic [psum_bw-1:0] mem [depth];
  logic [aw:0] wptr, rptr;
  logic acc;
  assign empty = wptr == rptr;
  assign full = wptr[aw-1:0] == rptr[aw-1:0] && wptr[aw] != rptr[aw];
  // a pop in the same cycle frees the slot, so a write to a full column is still taken
  assign acc = wr && (!full || pop);
  assign drop = wr && !acc;
  assign dout = mem[rptr[aw-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (acc) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (acc) mem[wptr[aw-1:0]] <= din;
endmodule

// File: rtl/mac_out_collector.sv
// mac_out_collector: deskews per-column MAC array outputs into aligned rows for the SRAM writer
// clk, reset (async active-low), bus (slave modport of mac_out_collector_if)
// Optional MAC_OUT_COLLECTOR_RELU_EN: negative head psums read out as zero
module mac_out_collector import mac_out_collector_pkg::*; #(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth = OUT_DEPTH
) (
  input logic clk,
  input logic reset,
  mac_out_collector_if.slave bus
);
  logic [col-1:0] empty, full, drop;
  logic pop, ovf;
  assign pop = bus.rd && bus.o_valid;
  assign bus.o_valid = &(~empty);
  assign bus.o_full = |full;
  assign bus.o_overflow = ovf;
  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] head;
    mac_out_col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_fifo (
      .clk(clk),
      .reset(reset),
      .din(bus.in[psum_bw*g +: psum_bw]),
      .wr(bus.wr[g]),
      .pop(pop),
      .dout(head),
      .empty(empty[g]),
      .full(full[g]),
      .drop(drop[g])
    );
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    assign bus.out[psum_bw*g +: psum_bw] = head[psum_bw-1] ? '0 : head;
`else
    assign bus.out[psum_bw*g +: psum_bw] = head;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf <= 1'b0;
    else if (|drop) ovf <= 1'b1;
endmodule

// File: tb/tb_mac_out_collector.sv
// tb_mac_out_collector: table vectors, corner sequences and random traffic against a queue model
module tb_mac_out_collector;
  import mac_out_collector_pkg::*;
  localparam int C = 8;
  localparam int W = 16;
  localparam int D = 16;
  typedef struct {
    logic [C-1:0] wr;
    logic [W*C-1:0] in;
    logic rd;
    logic exp_valid;
    logic exp_full;
    logic exp_ovf;
    logic chk_out;
    logic [W*C-1:0] exp_out;
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  mac_out_collector_if #(.col(C), .psum_bw(W)) bus();
  mac_out_collector #(.col(C), .psum_bw(W), .depth(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  psum_t mq [C][$];
  logic m_ovf;
  vec_t vec [10];
  logic [W*C-1:0] got [$];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [W-1:0] relu(input psum_t v);
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    return v < 0 ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic m_valid();
    for (int c = 0; c < C; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < C; c++) if (mq[c].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W*C-1:0] m_out();
    logic [W*C-1:0] o = '0;
    for (int c = 0; c < C; c++) if (mq[c].size() != 0) o[W*c +: W] = relu(mq[c][0]);
    return o;
  endfunction

  function automatic logic [W*C-1:0] rowvec(input int k);
    logic [W*C-1:0] v;
    for (int c = 0; c < C; c++) v[W*c +: W] = 16'h1000 + 16'(k * 8 + c);
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < C; c++) mq[c].delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_update(input logic [C-1:0] w, input logic [W*C-1:0] d, input logic r);
    if (r && m_valid()) for (int c = 0; c < C; c++) void'(mq[c].pop_front());
    for (int c = 0; c < C; c++)
      if (w[c]) begin
        if (mq[c].size() < D) mq[c].push_back(psum_t'(d[W*c +: W]));
        else m_ovf = 1'b1;
      end
  endtask

  task automatic step(input logic [C-1:0] w, input logic [W*C-1:0] d, input logic r);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    @(posedge clk);
    model_update(w, d, r);
    #1;
    chk("m_valid", bus.o_valid, m_valid());
    chk("m_full", bus.o_full, m_full());
    chk("m_ovf", bus.o_overflow, m_ovf);
    if (m_valid()) chk("m_out", bus.out, m_out());
  endtask

  task automatic do_reset();
    bus.wr = '0;
    bus.rd = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [W*C-1:0] v;
    logic [W-1:0] e16;
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;
    model_clear();
    reset = 1'b0;
    bus.wr = 8'hFF;
    bus.in = {4{$urandom}};
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_valid", bus.o_valid, 1'b0);
      chk("rst_full", bus.o_full, 1'b0);
      chk("rst_ovf", bus.o_overflow, 1'b0);
    end
    reset = 1'b1;
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("post_rst_valid", bus.o_valid, 1'b0);

    v = '0;
    for (int c = 0; c < C; c++) v[W*c +: W] = 16'h0100 + 16'(c);
    for (int c = 0; c < C; c++) begin
      vec[c] = '{wr: 8'(1 << c), in: '0, rd: 1'b0, exp_valid: c == C - 1, exp_full: 1'b0,
                 exp_ovf: 1'b0, chk_out: c == C - 1, exp_out: v};
      vec[c].in[W*c +: W] = 16'h0100 + 16'(c);
    end
    vec[8] = '{wr: '0, in: '0, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0, chk_out: 1'b0, exp_out: '0};
    vec[9] = '{wr: '0, in: '0, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0, chk_out: 1'b0, exp_out: '0};
    for (int i = 0; i < 10; i++) begin
      step(vec[i].wr, vec[i].in, vec[i].rd);
      chk($sformatf("tbl%0d_valid", i), bus.o_valid, vec[i].exp_valid);
      chk($sformatf("tbl%0d_full", i), bus.o_full, vec[i].exp_full);
      chk($sformatf("tbl%0d_ovf", i), bus.o_overflow, vec[i].exp_ovf);
      if (vec[i].chk_out) chk($sformatf("tbl%0d_out", i), bus.out, vec[i].exp_out);
    end

    do_reset();
    for (int i = 1; i <= 17; i++) begin
      v = '0;
      v[63:48] = 16'(i);
      step(8'h08, v, 1'b0);
      if (i == 15) chk("col3_not_full_15", bus.o_full, 1'b0);
      if (i == 16) begin
        chk("col3_full_16", bus.o_full, 1'b1);
        chk("col3_no_ovf_16", bus.o_overflow, 1'b0);
      end
    end
    chk("col3_ovf_17", bus.o_overflow, 1'b1);
    for (int i = 0; i < D; i++) step(8'hF7, rowvec(i), 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("col3_pop%0d", i), bus.out[63:48], 16'(i));
      step('0, '0, 1'b1);
    end
    chk("col3_drained", bus.o_valid, 1'b0);

    do_reset();
    for (int i = 0; i < D; i++) step(8'hFF, rowvec(i), 1'b0);
    chk("all_full", bus.o_full, 1'b1);
    step(8'hFF, rowvec(99), 1'b1);
    chk("simul_no_ovf", bus.o_overflow, 1'b0);
    chk("simul_full", bus.o_full, 1'b1);
    chk("simul_head", bus.out, rowvec(1));
    for (int i = 0; i < 15; i++) step('0, '0, 1'b1);
    chk("simul_new_row", bus.out, rowvec(99));
    chk("simul_valid", bus.o_valid, 1'b1);

    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", bus.o_valid, 1'b0);
    chk("async_rst_full", bus.o_full, 1'b0);
    model_clear();
    reset = 1'b1;
    step(8'h01, rowvec(5), 1'b0);
    step('0, '0, 1'b1);
    chk("ign_rd_valid", bus.o_valid, 1'b0);
    step(8'hFE, rowvec(6), 1'b0);
    chk("ign_rd_valid_after", bus.o_valid, 1'b1);
    chk("ign_rd_head", bus.out[15:0], 16'h1028);

    do_reset();
    for (int k = 0; k < 50; k++) begin
      logic r;
      r = bus.o_valid;
      if (r) got.push_back(bus.out);
      step(k < 40 ? 8'hFF : 8'h00, rowvec(k), r);
    end
    chk("stream_count", 128'(got.size()), 128'(40));
    for (int k = 0; k < 40 && k < got.size(); k++) chk($sformatf("stream_row%0d", k), got[k], rowvec(k));

    do_reset();
    v = rowvec(0);
    v[15:0] = 16'hFFF6;
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    e16 = 16'h0000;
`else
    e16 = 16'hFFF6;
`endif
    step(8'hFF, v, 1'b0);
    chk("relu_col0", bus.out[15:0], e16);
    chk("relu_col1", bus.out[31:16], 16'h1001);

    do_reset();
    for (int i = 0; i < 400; i++)
      step(8'($urandom), {4{$urandom}}, i < 200 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
